paddle_link_rx: RTL and testbench

Serial receiver for the second player's paddle state in two-board Pong. Deserialises 8N1 UART frames from the peer board, checks framing (and optionally a checksum), and presents a stable, atomically updated `ypos_one` / `mouse_left_one` pair. It runs in the pixel clock domain and feeds the `ypos_one` and `mouse_left_one` inputs of the game top, ahead of the mouse delay stage. It also reports link health.

---
 rtl/pong_link_pkg.sv | 36 +++
 rtl/paddle_link_rx_if.sv | 22 ++
 rtl/paddle_link_rx_uart_rx_byte.sv | 118 +++++++++++
 rtl/paddle_link_rx.sv | 168 ++++++++++++++++
 tb/tb_paddle_link_rx.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/pong_link_pkg.sv
// Shared constants, state types and helpers for the two-board Pong paddle link.
// PADDLE_LINK_CHECKSUM_EN adds the CHK byte and the GOT_B2 frame state.
package pong_link_pkg;

    localparam logic [7:0] LINK_HDR      = 8'hA5;
    localparam logic [7:0] LINK_CHK_SALT = 8'h5A;
    localparam int         YPOS_W        = 10;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        GOT_HDR = 2'd1,
`ifdef PADDLE_LINK_CHECKSUM_EN
        GOT_B1  = 2'd2,
        GOT_B2  = 2'd3
`else
        GOT_B1  = 2'd2
`endif
    } frame_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    function automatic logic [7:0] link_chk(input logic [7:0] b1, input logic [7:0] b2);
        return b1 ^ b2 ^ LINK_CHK_SALT;
    endfunction

    function automatic logic [YPOS_W-1:0] clamp_ypos(input logic [YPOS_W-1:0] y,
                                                     input logic [YPOS_W-1:0] ymax);
        return (y > ymax) ? ymax : y;
    endfunction

endpackage

// File: rtl/paddle_link_rx_if.sv
// Serial line in, peer paddle state and link health out.
interface paddle_link_rx_if;
    import pong_link_pkg::*;

    logic              rx;
    logic [YPOS_W-1:0] ypos_one;
    logic              mouse_left_one;
    logic              frame_valid;
    logic              frame_err;
    logic              link_up;

    modport master (
        input  rx,
        output ypos_one, mouse_left_one, frame_valid, frame_err, link_up
    );

    modport slave (
        output rx,
        input  ypos_one, mouse_left_one, frame_valid, frame_err, link_up
    );

endinterface

// File: rtl/paddle_link_rx_uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser, start-glitch rejection, centre sampling.
// byte_valid/ferr are single-cycle strobes at the stop-bit sample.
module uart_rx_byte
    import pong_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 564
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       ferr,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]       sync_q, sync_d;
    logic             rx_prev_q, rx_prev_d;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             rx_s;

    assign rx_s = sync_q[1];
    assign data = shift_q;
    assign busy = (state_q != RX_IDLE);

    // Bit-timing state machine and strobe generation.
    always_comb begin
        sync_d     = {sync_q[0], rx};
        rx_prev_d  = rx_s;
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        ferr       = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    // A start bit that is high again at mid-bit was only a glitch.
                    if (rx_s) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_s) begin
                        byte_valid = 1'b1;
                    end else begin
                        ferr = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Receiver state register; the synchroniser resets to the idle (high) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
        end else begin
            sync_q    <= sync_d;
            rx_prev_q <= rx_prev_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
        end
    end

endmodule

// File: rtl/paddle_link_rx.sv
// Peer paddle receiver: frame parser, position clamp, gap timer and link watchdog.
// Define PADDLE_LINK_CHECKSUM_EN for 4-byte frames with a checked CHK byte.
module paddle_link_rx
    import pong_link_pkg::*;
#(
    parameter int CLK_HZ       = 65_000_000,
    parameter int BAUD         = 115_200,
    parameter int YPOS_MAX     = 767,
    parameter int GAP_CYCLES   = 2 * 10 * ((CLK_HZ + BAUD / 2) / BAUD),
    parameter int LINK_TIMEOUT = 6_500_000
) (
    input  logic             clk,
    input  logic             rst,
    paddle_link_rx_if.master link
);

    localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int GAP_W        = $clog2(GAP_CYCLES + 1);
    localparam int WD_W         = $clog2(LINK_TIMEOUT + 1);
    localparam logic [GAP_W-1:0]  GAP_L  = GAP_W'(GAP_CYCLES);
    localparam logic [WD_W-1:0]   WD_L   = WD_W'(LINK_TIMEOUT);
    localparam logic [YPOS_W-1:0] YMAX_L = YPOS_W'(YPOS_MAX);

    logic [7:0] rx_data;
    logic       rx_valid, rx_ferr, rx_busy;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk        (clk),
        .rst        (rst),
        .rx         (link.rx),
        .data       (rx_data),
        .byte_valid (rx_valid),
        .ferr       (rx_ferr),
        .busy       (rx_busy)
    );

    frame_state_e      state_q, state_d;
    logic [7:0]        b1_q, b1_d, b2_q, b2_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [YPOS_W-1:0] ypos_q, ypos_d;
    logic              mouse_q, mouse_d;
    logic              fv_q, fv_d, fe_q, fe_d, link_q, link_d;
    logic              commit, reject;
    logic [YPOS_W-1:0] commit_y;

    // Frame parser: header hunt, byte capture, validation and gap timeout.
    always_comb begin
        state_d  = state_q;
        b1_d     = b1_q;
        b2_d     = b2_q;
        commit   = 1'b0;
        reject   = 1'b0;
        commit_y = {b1_q[1:0], b2_q};
        if (rx_ferr) begin
            state_d = HUNT;
            reject  = (state_q != HUNT);
        end else if (rx_valid) begin
            case (state_q)
                HUNT: begin
                    if (rx_data == LINK_HDR) begin
                        state_d = GOT_HDR;
                    end else begin
                        state_d = HUNT;
                    end
                end
                GOT_HDR: begin
                    b1_d    = rx_data;
                    state_d = GOT_B1;
                end
                GOT_B1: begin
                    b2_d = rx_data;
`ifdef PADDLE_LINK_CHECKSUM_EN
                    state_d = GOT_B2;
`else
                    state_d  = HUNT;
                    commit_y = {b1_q[1:0], rx_data};
                    if (b1_q[6:2] == 5'd0) begin
                        commit = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
`endif
                end
`ifdef PADDLE_LINK_CHECKSUM_EN
                GOT_B2: begin
                    state_d = HUNT;
                    if ((rx_data == link_chk(b1_q, b2_q)) && (b1_q[6:2] == 5'd0)) begin
                        commit = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = HUNT;
                end
            endcase
        end else if ((state_q != HUNT) && (gap_q == GAP_L)) begin
            state_d = HUNT;
            reject  = 1'b1;
        end else begin
            state_d = state_q;
        end
    end

    // Gap timer runs only mid-frame while the byte receiver is idle.
    always_comb begin
        if ((state_q == HUNT) || rx_busy || rx_valid) begin
            gap_d = '0;
        end else if (gap_q != GAP_L) begin
            gap_d = gap_q + GAP_W'(1);
        end else begin
            gap_d = gap_q;
        end
    end

    // Output commit and watchdog; a commit in the expiry cycle keeps the link up.
    always_comb begin
        fv_d = commit;
        fe_d = reject;
        if (commit) begin
            wd_d    = '0;
            link_d  = 1'b1;
            ypos_d  = clamp_ypos(commit_y, YMAX_L);
            mouse_d = b1_q[7];
        end else begin
            wd_d    = (wd_q == WD_L) ? wd_q : (wd_q + WD_W'(1));
            link_d  = (wd_d == WD_L) ? 1'b0 : link_q;
            ypos_d  = ypos_q;
            mouse_d = link_d ? mouse_q : 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            b1_q    <= 8'h00;
            b2_q    <= 8'h00;
            gap_q   <= '0;
            wd_q    <= '0;
            ypos_q  <= '0;
            mouse_q <= 1'b0;
            fv_q    <= 1'b0;
            fe_q    <= 1'b0;
            link_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            gap_q   <= gap_d;
            wd_q    <= wd_d;
            ypos_q  <= ypos_d;
            mouse_q <= mouse_d;
            fv_q    <= fv_d;
            fe_q    <= fe_d;
            link_q  <= link_d;
        end
    end

    assign link.ypos_one       = ypos_q;
    assign link.mouse_left_one = mouse_q;
    assign link.frame_valid    = fv_q;
    assign link.frame_err      = fe_q;
    assign link.link_up        = link_q;

endmodule

// File: tb/tb_paddle_link_rx.sv
// Directed bench for paddle_link_rx with scaled-down baud, gap and watchdog timing.
module tb_paddle_link_rx;
    import pong_link_pkg::*;

    localparam int CPB    = 8;
    localparam int GAP    = 160;
    localparam int LT     = 3000;
    localparam int YMAX   = 767;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    paddle_link_rx_if lif();

    paddle_link_rx #(
        .CLK_HZ       (8_000_000),
        .BAUD         (1_000_000),
        .YPOS_MAX     (YMAX),
        .GAP_CYCLES   (GAP),
        .LINK_TIMEOUT (LT)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .link (lif)
    );

    typedef struct {
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] chk;
        int         exp_y;
        int         exp_m;
        int         exp_v;
        int         exp_e;
    } vec_t;

    vec_t vecs[9];
    int   n_vecs;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vld_cnt = 0;
    int   err_cnt = 0;
    int   v0, e0;

    always @(negedge clk) begin
        if (lif.frame_valid === 1'b1) vld_cnt <= vld_cnt + 1;
        if (lif.frame_err === 1'b1)   err_cnt <= err_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        lif.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            lif.rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        lif.rx = stop_bit;
        repeat (CPB) @(negedge clk);
        lif.rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] chk);
        send_byte(LINK_HDR, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
`ifdef PADDLE_LINK_CHECKSUM_EN
        send_byte(chk, 1'b1);
`else
        if (chk === 8'hxx) lif.rx = 1'b1;
`endif
    endtask

    task automatic mark();
        v0 = vld_cnt;
        e0 = err_cnt;
    endtask

    initial begin
        vecs[0] = '{8'h81, 8'h2C, 8'hF7, 300, 1, 1, 0};
        vecs[1] = '{8'h03, 8'hFF, 8'hA6, 767, 0, 1, 0};
        vecs[2] = '{8'h80, 8'h00, 8'hDA,   0, 1, 1, 0};
        vecs[3] = '{8'h02, 8'hFF, 8'hA7, 767, 0, 1, 0};
        vecs[4] = '{8'h83, 8'h00, 8'hD9, 767, 1, 1, 0};
        vecs[5] = '{8'h81, 8'hA5, 8'h7E, 421, 1, 1, 0};
        vecs[6] = '{8'h05, 8'h2C, 8'h73, 421, 1, 0, 1};
        vecs[7] = '{8'h41, 8'h2C, 8'h37, 421, 1, 0, 1};
`ifdef PADDLE_LINK_CHECKSUM_EN
        vecs[8] = '{8'h81, 8'h2C, 8'h00, 421, 1, 0, 1};
        n_vecs = 9;
`else
        vecs[8] = '{8'h00, 8'h00, 8'h00, 0, 0, 0, 0};
        n_vecs = 8;
`endif

        lif.rx = 1'b1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("reset_ypos", int'(lif.ypos_one), 0);
        check("reset_mouse", int'(lif.mouse_left_one), 0);
        check("reset_link", int'(lif.link_up), 0);
        check("reset_fv", int'(lif.frame_valid), 0);
        check("reset_fe", int'(lif.frame_err), 0);
        check("reset_pulses", vld_cnt + err_cnt, 0);

        // Start glitch, junk bytes and a framing error while hunting: all silent.
        mark();
        lif.rx = 1'b0;
        repeat (2) @(negedge clk);
        lif.rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (4) @(negedge clk);
        check("hunt_noise_err", err_cnt - e0, 0);
        check("hunt_noise_vld", vld_cnt - v0, 0);

        for (int i = 0; i < n_vecs; i++) begin
            mark();
            send_frame(vecs[i].b1, vecs[i].b2, vecs[i].chk);
            repeat (4) @(negedge clk);
            check($sformatf("v%0d_vld", i), vld_cnt - v0, vecs[i].exp_v);
            check($sformatf("v%0d_err", i), err_cnt - e0, vecs[i].exp_e);
            check($sformatf("v%0d_ypos", i), int'(lif.ypos_one), vecs[i].exp_y);
            check($sformatf("v%0d_mouse", i), int'(lif.mouse_left_one), vecs[i].exp_m);
            check($sformatf("v%0d_link", i), int'(lif.link_up), 1);
        end

        // Framing error mid-frame, then recovery.
        mark();
        send_byte(LINK_HDR, 1'b1);
        send_byte(8'h81, 1'b0);
        repeat (4) @(negedge clk);
        check("ferr_mid_err", err_cnt - e0, 1);
        check("ferr_mid_vld", vld_cnt - v0, 0);
        mark();
        send_frame(8'h80, 8'h00, 8'hDA);
        repeat (4) @(negedge clk);
        check("ferr_recover_vld", vld_cnt - v0, 1);
        check("ferr_recover_ypos", int'(lif.ypos_one), 0);

        // Inter-byte gap timeout, then recovery.
        mark();
        send_byte(LINK_HDR, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (GAP + 240) @(negedge clk);
        check("gap_err", err_cnt - e0, 1);
        check("gap_vld", vld_cnt - v0, 0);
        mark();
        send_frame(8'h03, 8'hFF, 8'hA6);
        repeat (4) @(negedge clk);
        check("gap_recover_vld", vld_cnt - v0, 1);
        check("gap_recover_ypos", int'(lif.ypos_one), 767);

        // Link watchdog expiry.
        send_frame(8'h81, 8'h2C, 8'hF7);
        repeat (4) @(negedge clk);
        check("wd_pre_mouse", int'(lif.mouse_left_one), 1);
        repeat (LT - 200) @(negedge clk);
        check("wd_still_up", int'(lif.link_up), 1);
        repeat (400) @(negedge clk);
        check("wd_link_down", int'(lif.link_up), 0);
        check("wd_mouse_forced", int'(lif.mouse_left_one), 0);
        check("wd_ypos_hold", int'(lif.ypos_one), 300);

        // Reset in the middle of a frame discards the partial frame.
        send_frame(8'h81, 8'h2C, 8'hF7);
        repeat (4) @(negedge clk);
        check("mrst_pre_link", int'(lif.link_up), 1);
        send_byte(LINK_HDR, 1'b1);
        send_byte(8'h81, 1'b1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mrst_ypos", int'(lif.ypos_one), 0);
        check("mrst_mouse", int'(lif.mouse_left_one), 0);
        check("mrst_link", int'(lif.link_up), 0);
        mark();
        send_byte(8'h2C, 1'b1);
`ifdef PADDLE_LINK_CHECKSUM_EN
        send_byte(8'hF7, 1'b1);
`endif
        repeat (4) @(negedge clk);
        check("mrst_no_commit", vld_cnt - v0, 0);
        check("mrst_no_err", err_cnt - e0, 0);
        check("mrst_ypos_after", int'(lif.ypos_one), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
